// File: rtl/seg7_pkg.sv
// Shared 7-segment tables for the display driver and the readback monitor.
package seg7_pkg;

    // One BCD digit.
    typedef logic [3:0] bcd_t;

    // Segment patterns: bit6 = g .. bit0 = a, active-high.
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // One-cold, active-low digit selects.
    localparam logic [3:0] SEL_UNITS     = 4'b1110;
    localparam logic [3:0] SEL_TENS      = 4'b1101;
    localparam logic [3:0] SEL_HUNDREDS  = 4'b1011;
    localparam logic [3:0] SEL_THOUSANDS = 4'b0111;
    localparam logic [3:0] SEL_IDLE      = 4'b1111;

    // Packed {thousands,hundreds,tens,units} BCD to binary, 14 bits wide.
    function automatic logic [13:0] bcd4_to_bin(input logic [15:0] d);
        logic [13:0] acc;
        acc = 14'(d[3:0])
            + (14'(d[7:4])   * 14'd10)
            + (14'(d[11:8])  * 14'd100)
            + (14'(d[15:12]) * 14'd1000);
        return acc;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to BCD digit decoder; blank reads as 0.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern_in,
    output bcd_t       digit_out,
    output logic       valid_out
);

    // Table lookup; anything outside the table is flagged invalid.
    always_comb begin
        digit_out = 4'd0;
        valid_out = 1'b1;
        case (pattern_in)
            SEG_0:     digit_out = 4'd0;
            SEG_1:     digit_out = 4'd1;
            SEG_2:     digit_out = 4'd2;
            SEG_3:     digit_out = 4'd3;
            SEG_4:     digit_out = 4'd4;
            SEG_5:     digit_out = 4'd5;
            SEG_6:     digit_out = 4'd6;
            SEG_7:     digit_out = 4'd7;
            SEG_8:     digit_out = 4'd8;
            SEG_9:     digit_out = 4'd9;
            SEG_BLANK: digit_out = 4'd0;
            default: begin
                digit_out = 4'd0;
                valid_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Passive monitor of the multiplexed 7-segment bus: samples, decodes,
// assembles 4-digit frames and reports the binary value or a frame error.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_FRAMES = 1,
    parameter int TIMEOUT       = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  digit_sel_in,
    output logic [13:0] value,
    output logic        value_valid,
    output logic        frame_err,
    output logic [15:0] digits_bcd
);

    localparam int          TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [3:0]  STABLE_N = 4'(STABLE_FRAMES);

    // Stage 0: raw bus sample; smp_vld_q keeps the all-zero reset sample
    // from being mistaken for an illegal select.
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  sel_q, sel_d;
    logic        smp_vld_q, smp_vld_d;

    // Stage 1: frame assembly.
    logic [3:0]    seen_q, seen_d;
    logic          bad_q, bad_d;
    logic [15:0]   digits_q, digits_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          ev_q, ev_d;
    logic          ev_bad_q, ev_bad_d;
    logic [15:0]   ev_digits_q, ev_digits_d;
    logic          tmo_hit_s;

    // Stage 2: stability filter and outputs.
    logic [15:0] last_q, last_d;
    logic [3:0]  mcnt_q, mcnt_d;
    logic [13:0] value_q, value_d;
    logic [15:0] bcd_q, bcd_d;
    logic        vv_q, vv_d;
    logic        fe_q, fe_d;

    bcd_t        dec_digit_s;
    logic        dec_valid_s;
    logic        sel_ok_s;
    logic        sel_idle_s;
    logic [1:0]  pos_s;
    logic        same_s;

    seg7_pattern_decode u_decode (
        .pattern_in (seg_q),
        .digit_out  (dec_digit_s),
        .valid_out  (dec_valid_s)
    );

    // Stage 0 next state: segments and select captured in the same cycle.
    always_comb begin
        seg_d     = seg_in;
        sel_d     = digit_sel_in;
        smp_vld_d = 1'b1;
    end

    // Select classification into position, idle or illegal.
    always_comb begin
        sel_ok_s   = 1'b0;
        sel_idle_s = 1'b0;
        pos_s      = 2'd0;
        case (sel_q)
            SEL_UNITS:     begin sel_ok_s = 1'b1; pos_s = 2'd0; end
            SEL_TENS:      begin sel_ok_s = 1'b1; pos_s = 2'd1; end
            SEL_HUNDREDS:  begin sel_ok_s = 1'b1; pos_s = 2'd2; end
            SEL_THOUSANDS: begin sel_ok_s = 1'b1; pos_s = 2'd3; end
            SEL_IDLE:      begin sel_idle_s = 1'b1; end
            default:       begin sel_ok_s = 1'b0; end
        endcase
    end

    // Stage 1 next state: store digit, track completion and timeout.
    always_comb begin
        seen_d      = seen_q;
        bad_d       = bad_q;
        digits_d    = digits_q;
        cnt_d       = cnt_q;
        ev_d        = 1'b0;
        ev_bad_d    = 1'b0;
        ev_digits_d = ev_digits_q;
        tmo_hit_s   = 1'b0;

        if (smp_vld_q && sel_ok_s) begin
            digits_d[{pos_s, 2'b00} +: 4] = dec_digit_s;
            seen_d[pos_s]                 = 1'b1;
            if (!dec_valid_s) begin
                bad_d = 1'b1;
            end else begin
                bad_d = bad_q;
            end
        end else if (smp_vld_q && !sel_idle_s) begin
            bad_d = 1'b1;
        end else begin
            bad_d = bad_q;
        end

        // Completion takes priority over a timeout on the same edge.
        if (seen_d == 4'b1111) begin
            ev_d        = 1'b1;
            ev_bad_d    = bad_d;
            ev_digits_d = digits_d;
            seen_d      = 4'b0000;
            bad_d       = 1'b0;
            cnt_d       = '0;
        end else if ((seen_d != 4'b0000) || bad_d) begin
            if (cnt_q == TMO_LAST) begin
                tmo_hit_s = 1'b1;
                seen_d    = 4'b0000;
                bad_d     = 1'b0;
                cnt_d     = '0;
            end else begin
                cnt_d = cnt_q + TW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Stage 2 next state: match counting and output pulses.
    always_comb begin
        last_d  = last_q;
        mcnt_d  = mcnt_q;
        value_d = value_q;
        bcd_d   = bcd_q;
        vv_d    = 1'b0;
        fe_d    = tmo_hit_s;
        same_s  = (ev_digits_q == last_q);

        if (ev_q && ev_bad_q) begin
            fe_d = 1'b1;
        end else if (ev_q) begin
            last_d = ev_digits_q;
            if (!same_s) begin
                mcnt_d = 4'd1;
            end else if (mcnt_q != STABLE_N) begin
                mcnt_d = mcnt_q + 4'd1;
            end else begin
                mcnt_d = mcnt_q;
            end
            // Pulse only on arrival at the threshold, not while resting on it.
            if ((mcnt_d == STABLE_N) && (!same_s || (mcnt_q != STABLE_N))) begin
                vv_d    = 1'b1;
                value_d = bcd4_to_bin(ev_digits_q);
                bcd_d   = ev_digits_q;
            end else begin
                vv_d = 1'b0;
            end
        end else begin
            vv_d = 1'b0;
        end
    end

    // Stage 0 registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q     <= 7'd0;
            sel_q     <= 4'd0;
            smp_vld_q <= 1'b0;
        end else begin
            seg_q     <= seg_d;
            sel_q     <= sel_d;
            smp_vld_q <= smp_vld_d;
        end
    end

    // Stage 1 registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seen_q      <= 4'd0;
            bad_q       <= 1'b0;
            digits_q    <= 16'd0;
            cnt_q       <= '0;
            ev_q        <= 1'b0;
            ev_bad_q    <= 1'b0;
            ev_digits_q <= 16'd0;
        end else begin
            seen_q      <= seen_d;
            bad_q       <= bad_d;
            digits_q    <= digits_d;
            cnt_q       <= cnt_d;
            ev_q        <= ev_d;
            ev_bad_q    <= ev_bad_d;
            ev_digits_q <= ev_digits_d;
        end
    end

    // Stage 2 registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q  <= 16'd0;
            mcnt_q  <= 4'd0;
            value_q <= 14'd0;
            bcd_q   <= 16'd0;
            vv_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            last_q  <= last_d;
            mcnt_q  <= mcnt_d;
            value_q <= value_d;
            bcd_q   <= bcd_d;
            vv_q    <= vv_d;
            fe_q    <= fe_d;
        end
    end

    assign value       = value_q;
    assign value_valid = vv_q;
    assign frame_err   = fe_q;
    assign digits_bcd  = bcd_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: one instance with STABLE_FRAMES=1 and
// one with STABLE_FRAMES=2 share the same bus stimulus.
module tb_seg7_scan_capture;

    localparam logic [6:0] P0  = 7'b0111111;
    localparam logic [6:0] P1  = 7'b0000110;
    localparam logic [6:0] P2  = 7'b1011011;
    localparam logic [6:0] P3  = 7'b1001111;
    localparam logic [6:0] P4  = 7'b1100110;
    localparam logic [6:0] P5  = 7'b1101101;
    localparam logic [6:0] P7  = 7'b0000111;
    localparam logic [6:0] P8  = 7'b1111111;
    localparam logic [6:0] P9  = 7'b1101111;
    localparam logic [6:0] PBL = 7'b0000000;
    localparam logic [6:0] PBAD = 7'b1000000;
    localparam logic [3:0] SU  = 4'b1110;
    localparam logic [3:0] ST  = 4'b1101;
    localparam logic [3:0] SH  = 4'b1011;
    localparam logic [3:0] STH = 4'b0111;
    localparam logic [3:0] SI  = 4'b1111;

    logic        clk;
    logic        reset;
    logic [6:0]  seg_in;
    logic [3:0]  digit_sel_in;
    logic [13:0] value_a, value_b;
    logic        vv_a, vv_b;
    logic        fe_a, fe_b;
    logic [15:0] bcd_a, bcd_b;

    int n_eval;
    int n_fail;
    logic early_fe;

    seg7_scan_capture #(.STABLE_FRAMES(1), .TIMEOUT(64)) dut_a (
        .clk          (clk),
        .reset        (reset),
        .seg_in       (seg_in),
        .digit_sel_in (digit_sel_in),
        .value        (value_a),
        .value_valid  (vv_a),
        .frame_err    (fe_a),
        .digits_bcd   (bcd_a)
    );

    seg7_scan_capture #(.STABLE_FRAMES(2), .TIMEOUT(64)) dut_b (
        .clk          (clk),
        .reset        (reset),
        .seg_in       (seg_in),
        .digit_sel_in (digit_sel_in),
        .value        (value_b),
        .value_valid  (vv_b),
        .frame_err    (fe_b),
        .digits_bcd   (bcd_b)
    );

    // 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_eval++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one bus word, let one rising edge sample it, settle past the edge.
    task automatic step(input logic [6:0] p, input logic [3:0] s);
        seg_in       = p;
        digit_sel_in = s;
        @(posedge clk);
        #1;
    endtask

    // Units, tens, hundreds, thousands, then two idle cycles: returns just
    // after the second edge following the thousands sample.
    task automatic run_frame(input logic [6:0] pu, input logic [6:0] pt,
                             input logic [6:0] ph, input logic [6:0] pth);
        step(pu, SU);
        step(pt, ST);
        step(ph, SH);
        step(pth, STH);
        step(PBL, SI);
        step(PBL, SI);
    endtask

    initial begin
        n_eval       = 0;
        n_fail       = 0;
        reset        = 1'b1;
        seg_in       = PBL;
        digit_sel_in = SI;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_value", 16'(value_a), 16'd0);
        chk("rst_valid", 16'(vv_a), 16'd0);
        chk("rst_err",   16'(fe_a), 16'd0);
        chk("rst_bcd",   bcd_a, 16'd0);
        reset = 1'b0;
        step(PBL, SI);

        // Frame 273 with exact output timing.
        step(P3, SU);
        step(P7, ST);
        step(P2, SH);
        step(P0, STH);
        step(PBL, SI);
        chk("lat_e1_valid", 16'(vv_a), 16'd0);
        chk("lat_e1_err",   16'(fe_a), 16'd0);
        step(PBL, SI);
        chk("f273_valid", 16'(vv_a), 16'd1);
        chk("f273_value", 16'(value_a), 16'd273);
        chk("f273_bcd",   bcd_a, 16'h0273);
        chk("f273_b_valid", 16'(vv_b), 16'd0);
        chk("f273_b_value", 16'(value_b), 16'd0);
        step(PBL, SI);
        chk("f273_pulse_end", 16'(vv_a), 16'd0);

        // 274 three times: B updates only on the second, never on the third.
        run_frame(P4, P7, P2, P0);
        chk("f274a_valid", 16'(vv_a), 16'd1);
        chk("f274a_value", 16'(value_a), 16'd274);
        chk("f274a_b_valid", 16'(vv_b), 16'd0);
        chk("f274a_b_value", 16'(value_b), 16'd0);
        step(PBL, SI);
        run_frame(P4, P7, P2, P0);
        chk("f274b_a_repeat", 16'(vv_a), 16'd0);
        chk("f274b_b_valid", 16'(vv_b), 16'd1);
        chk("f274b_b_value", 16'(value_b), 16'd274);
        chk("f274b_b_bcd",   bcd_b, 16'h0274);
        step(PBL, SI);
        run_frame(P4, P7, P2, P0);
        chk("f274c_b_repeat", 16'(vv_b), 16'd0);
        chk("f274c_a_repeat", 16'(vv_a), 16'd0);
        step(PBL, SI);

        // Back to 273, then a frame with a bad tens pattern.
        run_frame(P3, P7, P2, P0);
        chk("f273r_valid", 16'(vv_a), 16'd1);
        chk("f273r_value", 16'(value_a), 16'd273);
        step(PBL, SI);
        run_frame(P3, PBAD, P2, P0);
        chk("badpat_err",   16'(fe_a), 16'd1);
        chk("badpat_valid", 16'(vv_a), 16'd0);
        chk("badpat_value", 16'(value_a), 16'd273);
        chk("badpat_b_err", 16'(fe_b), 16'd1);
        step(PBL, SI);
        chk("badpat_pulse_end", 16'(fe_a), 16'd0);

        // Timeout: first digit sampled on edge 0, error pulse after edge 64.
        step(P1, SU);
        step(P2, ST);
        step(P5, SH);
        early_fe = 1'b0;
        for (int n = 3; n <= 63; n++) begin
            step(PBL, SI);
            early_fe = early_fe | fe_a | vv_a;
        end
        chk("tmo_early", 16'(early_fe), 16'd0);
        step(PBL, SI);
        chk("tmo_err",   16'(fe_a), 16'd1);
        chk("tmo_valid", 16'(vv_a), 16'd0);
        chk("tmo_value", 16'(value_a), 16'd273);
        step(PBL, SI);
        chk("tmo_pulse_end", 16'(fe_a), 16'd0);
        run_frame(P5, P2, P1, P0);
        chk("f125_valid", 16'(vv_a), 16'd1);
        chk("f125_value", 16'(value_a), 16'd125);
        step(PBL, SI);

        // Illegal select 1100 in the middle of a frame.
        step(P1, SU);
        step(P8, 4'b1100);
        step(P2, ST);
        step(P3, SH);
        step(P0, STH);
        step(PBL, SI);
        step(PBL, SI);
        chk("badsel_err",   16'(fe_a), 16'd1);
        chk("badsel_value", 16'(value_a), 16'd125);
        step(PBL, SI);

        // Out-of-order arrival with units overwritten by 9.
        step(P0, STH);
        step(P3, SU);
        step(P9, SU);
        step(P4, SH);
        step(P2, ST);
        step(PBL, SI);
        step(PBL, SI);
        chk("ovw_valid", 16'(vv_a), 16'd1);
        chk("ovw_value", 16'(value_a), 16'd429);
        chk("ovw_bcd",   bcd_a, 16'h0429);
        step(PBL, SI);

        // Asynchronous reset in the middle of a frame.
        step(P4, SU);
        step(P0, ST);
        reset = 1'b1;
        #1;
        chk("mrst_value", 16'(value_a), 16'd0);
        chk("mrst_bcd",   bcd_a, 16'd0);
        chk("mrst_b_value", 16'(value_b), 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        early_fe = 1'b0;
        for (int n = 0; n < 4; n++) begin
            step(PBL, SI);
            early_fe = early_fe | fe_a | fe_b | vv_a;
        end
        chk("mrst_no_pulse", 16'(early_fe), 16'd0);
        run_frame(P0, P4, PBL, P0);
        chk("f40_valid", 16'(vv_a), 16'd1);
        chk("f40_value", 16'(value_a), 16'd40);
        chk("f40_bcd",   bcd_a, 16'h0040);
        chk("f40_b_valid", 16'(vv_b), 16'd0);
        step(PBL, SI);

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Passive monitor on the multiplexed 7-segment bus produced by the temperature display driver.
- Samples segment pattern and one-cold digit select every clock, decodes each digit and assembles a 4-digit frame.
- Converts the frame back to binary and reports it with a valid pulse, or flags a frame error.
- Used for on-chip display readback/self-check. Observes only; never drives the display.

Parameters:
- STABLE_FRAMES, 1: number of consecutive identical good frames required before value updates (1..15).
- TIMEOUT, 64: max cycles from first digit of a frame to frame completion before discard (>=8).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- seg_in  in  7  segment pattern, bit6=g .. bit0=a, active-high segments.
- digit_sel_in  in  4  one-cold, active-low digit select. 1110=units, 1101=tens, 1011=hundreds, 0111=thousands, 1111=idle.
- value  out  14  last accepted binary value, 0..9999.
- value_valid  out  1  one-cycle pulse when value updates.
- frame_err  out  1  one-cycle pulse when a frame is discarded.
- digits_bcd  out  16  last accepted frame, {thousands,hundreds,tens,units}.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. Asserting reset clears value, value_valid, frame_err, digits_bcd, all internal state and counters to 0. A partial frame is discarded; no error pulse is issued.
- Stage 0, input sampling:
  - seg_in and digit_sel_in are registered together every cycle; both belong to the same cycle.
- Stage 1, decode and store:
  - Patterns 0111111,0000110,1011011,1001111,1100110,1101101,1111101,0000111,1111111,1101111 decode to digits 0..9.
  - 0000000 (blank) decodes to 0.
  - Any other pattern is a bad pattern.
  - digit_sel_in=1111 means idle: nothing is stored and the seen mask is unchanged.
  - A valid one-cold select stores the decoded digit at that position and sets seen[pos].
  - Any other select value (zero or multiple lows) marks the frame bad.
  - A bad pattern on a valid select marks the frame bad.
  - A repeated position before completion overwrites the stored digit. Arrival order is free.
- Frame completion: when seen becomes 1111.
  - If the frame is good: value_n = u + 10*t + 100*h + 1000*th, computed at 14-bit width with no truncation.
  - If the frame is bad: frame_err pulses and value is held.
  - In both cases seen, the bad flag and the timeout counter clear on the same edge.
- Latency: value_valid / frame_err is high for exactly one cycle, starting 2 rising edges after the edge that samples the completing digit.
- Stability:
  - A good frame equal to the previous good frame increments the match count; a different frame resets the count to 1.
  - value, digits_bcd and value_valid update only when the count reaches STABLE_FRAMES.
  - The count saturates there. Repeats of the same frame do not re-pulse value_valid, but a different stable value does.
- Timeout:
  - The counter starts on the first stored digit of a frame and counts every cycle.
  - On reaching TIMEOUT with seen != 1111: frame_err pulses, and seen, bad and counter clear.
  - If completion and timeout occur on the same edge, completion wins.
- value_valid and frame_err are never high in the same cycle.
- A bad frame does not alter the match count.

Decomposition:
- Shared package seg7_pkg:
  - the ten segment-pattern constants and the blank constant;
  - the four select constants and the idle constant;
  - typedef for a BCD digit (4 bits).
- The package is shared with the display driver so both ends use one table.
- Sub-module seg7_pattern_decode: combinational, 7-bit pattern in, 4-bit digit plus valid out.

Test Plan:
- Reset, then drive units 3 (1001111/1110), tens 7 (0000111/1101), hundreds 2 (1011011/1011), thousands 0 (0111111/0111) -> value=273, digits_bcd=16'h0273, value_valid one cycle exactly 2 edges after the thousands sample.
- STABLE_FRAMES=2; frames 273, 274, 274 -> no update after 273 or the first 274; value=274 with one pulse after the second 274; a further 274 gives no pulse.
- Tens pattern 1000000 in a frame otherwise 273 -> frame_err pulse at completion, value stays 273, no value_valid.
- Three digits then idle 1111 for TIMEOUT=64 cycles -> frame_err at cycle 64 from first digit; following full frame 125 -> value=125.
- digit_sel_in=1100 mid-frame -> frame_err at completion. Separately, digits in order thousands, units, units(overwrite 9), hundreds, tens -> value uses units=9.
- Assert reset after two digits -> all outputs 0 immediately, no frame_err; next full frame 40 -> value=40.
